tensor_loader: RTL
==================

TENSOR_LOADER -- requirements
Module: tensor_loader

Interface
REQ-001 WIDTH, default 17, signed tensor element width written downstream.
REQ-002 PIX_W, default 8, unsigned input pixel width; SHALL satisfy WIDTH > PIX_W.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_data  input  PIX_W  unsigned pixel sample.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_sof  input  1  beat is first element of a tensor.
REQ-008 s_ready  output  1  loader accepts a beat this cycle.
REQ-009 tensor_ack  input  1  consumer has taken the held tensor.
REQ-010 row_addr  output  3  element row, 0..7.
REQ-011 col_addr  output  3  element column, 0..7.
REQ-012 cha_addr  output  2  element channel, 0..2.
REQ-013 data_out  output  WIDTH  signed converted element.
REQ-014 wr_en  output  1  one-cycle element write strobe.
REQ-015 tensor_valid  output  1  complete 3x8x8 tensor written and held.
REQ-016 sync_err  output  1  sticky s_sof misalignment flag.

Function
REQ-017 Beat SHALL be accepted iff s_valid && s_ready on a rising edge.
REQ-018 Scan order SHALL be col fastest (0..7), then row (0..7), then cha (0..2): 192 beats per tensor.
REQ-019 Beat accepted at edge N SHALL present wr_en=1 with registered addresses and data_out for exactly the cycle following edge N; wr_en=0 otherwise.
REQ-020 Address/data outputs SHALL hold their last values while wr_en=0.
REQ-021 FSM states LOAD, DRAIN, FULL; s_ready=1 only in LOAD.
REQ-022 LOAD -> DRAIN on accepting beat (cha=2,row=7,col=7); element counter wraps to 0.
REQ-023 DRAIN -> FULL unconditionally after one cycle; tensor_valid rises at the edge ending the final wr_en cycle.
REQ-024 FULL: tensor_valid=1; tensor_ack=1 -> LOAD, tensor_valid=0 and s_ready=1 from the next cycle.
REQ-025 tensor_ack SHALL be ignored in LOAD and DRAIN.
REQ-026 Accepted beat with s_sof=1 and counter != 0: beat written at (0,0,0), counter continues from 1, sync_err set.
REQ-027 Accepted beat with s_sof=1 at counter 0 or s_sof=0 at any count: normal, no error.
REQ-028 sync_err SHALL clear only on reset.

Reset
REQ-029 rst=1 SHALL immediately force state LOAD, counter 0, wr_en=0, tensor_valid=0, sync_err=0, all address/data outputs 0, s_ready=0.
REQ-030 s_ready SHALL be 1 from the first rising edge after rst deasserts.
REQ-031 Reset mid-tensor SHALL discard the partial tensor; next accepted beat goes to (0,0,0).

Configuration
REQ-032 Macro TENSOR_LOADER_CENTER_EN defined: data_out = sign-extended (s_data - 2^(PIX_W-1)), e.g. 0 -> -128, 255 -> 127.
REQ-033 Macro undefined: data_out = zero-extended s_data, e.g. 255 -> 255; no other behaviour differs.

Verification
REQ-034 192 back-to-back beats, s_data=k mod 256 -> 192 wr_en pulses; beat 0 at (0,0,0), beat 9 at (cha0,row1,col1), beat 191 at (2,7,7); tensor_valid=1 at the edge ending the final wr_en cycle.
REQ-035 FULL with s_valid held 10 cycles, no ack -> s_ready=0, no wr_en, tensor_valid stays 1; ack 1 cycle -> s_ready=1 next cycle, next beat at (0,0,0).
REQ-036 s_valid toggling 1-0-1 over 192 beats -> addresses advance only on accepted beats, no skipped or duplicated address.
REQ-037 s_sof=1 on beat 50 -> that beat written at (0,0,0), sync_err=1, beat 51 at (0,0,1); sync_err persists past tensor_ack.
REQ-038 rst pulsed asynchronously after beat 100 -> all outputs 0 without clock edge; next beat at (0,0,0), sync_err=0.
REQ-039 TENSOR_LOADER_CENTER_EN defined, s_data 0/128/255 -> data_out 17'h1FF80/0/127; undefined -> 0/128/255.

Source files
------------

// File: rtl/tensor_loader_if.sv
// Bus bundle between a pixel stream source / tensor consumer and tensor_loader.
// master: stream source plus consumer side (drives pixels and tensor_ack).
// slave:  tensor_loader side (drives s_ready and the element write port).
// Handshake: a beat transfers on a rising edge where s_valid && s_ready; the
// source may raise s_valid at any time, and s_ready never depends on s_valid.
// state_dbg carries the loader FSM state for observation only.
interface tensor_loader_if #(
    parameter int WIDTH = 17,
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0]        s_data;
    logic                    s_valid;
    logic                    s_sof;
    logic                    s_ready;
    logic                    tensor_ack;
    logic [2:0]              row_addr;
    logic [2:0]              col_addr;
    logic [1:0]              cha_addr;
    logic signed [WIDTH-1:0] data_out;
    logic                    wr_en;
    logic                    tensor_valid;
    logic                    sync_err;
    logic [1:0]              state_dbg;

    modport master (
        output s_data, s_valid, s_sof, tensor_ack,
        input  s_ready, row_addr, col_addr, cha_addr, data_out,
               wr_en, tensor_valid, sync_err, state_dbg
    );

    modport slave (
        input  s_data, s_valid, s_sof, tensor_ack,
        output s_ready, row_addr, col_addr, cha_addr, data_out,
               wr_en, tensor_valid, sync_err, state_dbg
    );
endinterface

// File: rtl/tensor_loader.sv
// tensor_loader: converts a pixel stream into a 3x8x8 signed tensor written
// element by element (col fastest, then row, then channel), then holds the
// tensor until the consumer acknowledges it.
// Optional macro TENSOR_LOADER_CENTER_EN: centre pixels around zero
// (s_data - 2^(PIX_W-1)); otherwise pixels are zero-extended.
// WIDTH must be greater than PIX_W.
module tensor_loader #(
    parameter int WIDTH = 17,
    parameter int PIX_W = 8
) (
    input  logic clk,
    input  logic rst,
    tensor_loader_if.slave bus
);
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int PAD = WIDTH - PIX_W;
    localparam logic [WIDTH-1:0] BIAS = WIDTH'(1) << (PIX_W - 1);

    state_t                  state_q, state_d;
    logic [2:0]              col_q, col_d;
    logic [2:0]              row_q, row_d;
    logic [1:0]              cha_q, cha_d;
    logic                    s_ready_q, s_ready_d;
    logic                    wr_en_q, wr_en_d;
    logic                    tensor_valid_q, tensor_valid_d;
    logic                    sync_err_q, sync_err_d;
    logic [2:0]              row_addr_q, row_addr_d;
    logic [2:0]              col_addr_q, col_addr_d;
    logic [1:0]              cha_addr_q, cha_addr_d;
    logic signed [WIDTH-1:0] data_q, data_d;

    logic                    accept;
    logic                    resync;
    logic                    last;
    logic [2:0]              w_col, w_row;
    logic [1:0]              w_cha;
    logic [WIDTH-1:0]        pix_ext;
    logic signed [WIDTH-1:0] conv;

    // Pixel to tensor element conversion.
    always_comb begin
        pix_ext = {{PAD{1'b0}}, bus.s_data};
`ifdef TENSOR_LOADER_CENTER_EN
        conv = $signed(pix_ext - BIAS);
`else
        conv = $signed(pix_ext);
`endif
    end

    // Next-state logic: acceptance, sof resync, element counter, FSM, outputs.
    always_comb begin
        accept = bus.s_valid && s_ready_q;
        // A start-of-frame mid-tensor restarts the tensor at element 0.
        resync = accept && bus.s_sof && ({cha_q, row_q, col_q} != 8'd0);
        last   = accept && !resync && (cha_q == 2'd2) && (row_q == 3'd7) && (col_q == 3'd7);

        w_col = resync ? 3'd0 : col_q;
        w_row = resync ? 3'd0 : row_q;
        w_cha = resync ? 2'd0 : cha_q;

        col_d = col_q;
        row_d = row_q;
        cha_d = cha_q;
        if (accept) begin
            if (last) begin
                col_d = 3'd0;
                row_d = 3'd0;
                cha_d = 2'd0;
            end else begin
                col_d = w_col + 3'd1;
                row_d = w_row;
                cha_d = w_cha;
                if (w_col == 3'd7) begin
                    row_d = w_row + 3'd1;
                    if (w_row == 3'd7) begin
                        cha_d = w_cha + 2'd1;
                    end
                end
            end
        end

        state_d = state_q;
        case (state_q)
            LOAD:    if (last) state_d = DRAIN;
            DRAIN:   state_d = FULL;
            FULL:    if (bus.tensor_ack) state_d = LOAD;
            default: state_d = LOAD;
        endcase

        s_ready_d      = (state_d == LOAD);
        tensor_valid_d = (state_d == FULL);
        sync_err_d     = sync_err_q || resync;
        wr_en_d        = accept;

        // Address/data hold their last written values between strobes.
        row_addr_d = row_addr_q;
        col_addr_d = col_addr_q;
        cha_addr_d = cha_addr_q;
        data_d     = data_q;
        if (accept) begin
            row_addr_d = w_row;
            col_addr_d = w_col;
            cha_addr_d = w_cha;
            data_d     = conv;
        end
    end

    // State register: FSM, counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LOAD;
            col_q          <= 3'd0;
            row_q          <= 3'd0;
            cha_q          <= 2'd0;
            s_ready_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            tensor_valid_q <= 1'b0;
            sync_err_q     <= 1'b0;
            row_addr_q     <= 3'd0;
            col_addr_q     <= 3'd0;
            cha_addr_q     <= 2'd0;
            data_q         <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            cha_q          <= cha_d;
            s_ready_q      <= s_ready_d;
            wr_en_q        <= wr_en_d;
            tensor_valid_q <= tensor_valid_d;
            sync_err_q     <= sync_err_d;
            row_addr_q     <= row_addr_d;
            col_addr_q     <= col_addr_d;
            cha_addr_q     <= cha_addr_d;
            data_q         <= data_d;
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.tensor_valid = tensor_valid_q;
    assign bus.sync_err     = sync_err_q;
    assign bus.row_addr     = row_addr_q;
    assign bus.col_addr     = col_addr_q;
    assign bus.cha_addr     = cha_addr_q;
    assign bus.data_out     = data_q;
    assign bus.state_dbg    = state_q;
endmodule
